traffic_phase_sequencer: RTL

//  Timed phase sequencer for the highway / country-road junction.

---
 rtl/traffic_phase_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/traffic_phase_sequencer.sv
// Highway / country-road junction phase sequencer with pedestrian latch and emergency preempt.
// Lamps, walk and state are decoded from registered state only (Moore).
module traffic_phase_sequencer #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 10,
  parameter int Y_TIME     = 3,
  parameter int R_TIME     = 2,
  parameter int CMAX_GREEN = 8,
  parameter int PED_TIME   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       x,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [1:0] Hwy,
  output logic [1:0] Cnrty,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR1 = 3'd2,
    S_CG  = 3'd3,
    S_CY  = 3'd4,
    S_AR2 = 3'd5,
    S_PED = 3'd6
  } state_e;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic             expire;

  // Timer is loaded with D-1 so a phase lasts exactly D ticks.
  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    case (s)
      S_HG:         return CNT_W'(MIN_GREEN - 1);
      S_HY, S_CY:   return CNT_W'(Y_TIME - 1);
      S_AR1, S_AR2: return CNT_W'(R_TIME - 1);
      S_CG:         return CNT_W'(CMAX_GREEN - 1);
      S_PED:        return CNT_W'(PED_TIME - 1);
      default:      return CNT_W'(MIN_GREEN - 1);
    endcase
  endfunction

  assign expire = tick && (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ped_pend_d = ped_pend_q | ped_req;
    ped_ack_d  = 1'b0;

    if (tick && (timer_q != '0)) begin
      timer_d = timer_q - CNT_W'(1);
    end

    case (state_q)
      S_HG: begin
        if (!emerg && expire && (x || ped_pend_q)) state_d = S_HY;
      end
      S_HY: begin
        if (expire) state_d = S_AR1;
      end
      S_AR1: begin
        if (expire) begin
          if (emerg)           state_d = S_AR2;
          else if (ped_pend_q) state_d = S_PED;
          else if (x)          state_d = S_CG;
          else                 state_d = S_HG;
        end
      end
      S_CG: begin
        if (emerg || (tick && !x) || expire) state_d = S_CY;
      end
      S_CY: begin
        if (expire) state_d = S_AR2;
      end
      S_AR2: begin
        if (expire) state_d = S_HG;
      end
      S_PED: begin
        // Preempt abandons the walk without acknowledging, so the request stays pending.
        if (emerg) begin
          state_d = S_AR2;
        end else if (expire) begin
          state_d    = x ? S_CG : S_HG;
          ped_pend_d = ped_req;
          ped_ack_d  = 1'b1;
        end
      end
      default: state_d = S_HG;
    endcase

    // Holding green under preempt restarts the minimum green once it clears.
    if (state_d != state_q) begin
      timer_d = load_val(state_d);
    end else if ((state_q == S_HG) && emerg) begin
      timer_d = load_val(S_HG);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HG;
      timer_q    <= CNT_W'(MIN_GREEN - 1);
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  always_comb begin
    Hwy   = LAMP_RED;
    Cnrty = LAMP_RED;
    case (state_q)
      S_HG:    Hwy   = LAMP_GREEN;
      S_HY:    Hwy   = LAMP_YELLOW;
      S_CG:    Cnrty = LAMP_GREEN;
      S_CY:    Cnrty = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign walk    = (state_q == S_PED);
  assign ped_ack = ped_ack_q;
  assign state   = state_q;

endmodule
